stim_check: RTL and testbench
=============================

# stim_check

Self-checking stimulus engine for the increment datapath of the top-level example. On `start` it drives a deterministic sequence of vectors onto the small (2-bit), quad (40-bit) and wide (70-bit) inputs. It checks every returned result against `in + 1` modulo 2^W, applying a configurable return latency. It counts mismatches, records the first failing index and reports pass/fail, so Verilator runs self-check without a C++ scoreboard.

## Interface
- `NUM_VECTORS`, default 256: vectors per run. Legal range is 2..65535.
- `LATENCY`, default 0: cycles from driving a vector to its result being valid on `res_*`. Legal range is 0..4.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset_l` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request to begin a run. Honoured only in IDLE or DONE.
- `drv_small` out 2: stimulus for the small path.
- `drv_quad` out 40: stimulus for the quad path.
- `drv_wide` out 70: stimulus for the wide path.
- `res_small` in 2: returned small result.
- `res_quad` in 40: returned quad result.
- `res_wide` in 70: returned wide result.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`; 1 when `err_count` is 0.
- `err_count` out 16: number of mismatching vectors; saturates at 16'hFFFF.
- `first_err_idx` out 16: index of the first mismatching vector; 16'hFFFF when there is none.

## Operation
- States are IDLE, RUN, DRAIN and DONE.
- IDLE→RUN when `start` is sampled high. The same edge clears `err_count`, sets `first_err_idx` to FFFF, zeroes the vector index and seeds the LFSR to 40'h1.
- RUN drives one vector per cycle at index i = 0..NUM_VECTORS-1.
  - i=0: all three drive buses are all-ones; expected results are zero (wrap case).
  - i=1: all drive buses are zero; expected results are 1.
  - i≥2: `drv_small`=i[1:0], `drv_quad`=lfsr, `drv_wide`={lfsr[29:0],lfsr}.
  - LFSR: 40-bit Fibonacci, shifts left, feedback = q[39]^q[37]^q[20]^q[18]. It advances once per vector from i=2 onward.
- Transitions after the last vector:
  - LATENCY=0: RUN→DONE.
  - Otherwise: RUN→DRAIN, then stay in DRAIN for LATENCY cycles, then →DONE.
  - During DRAIN the drive buses hold zero.
- Expected values:
  - Computed as drive+1, truncated to each bus width.
  - Carried through a LATENCY-deep shift register together with a valid bit and the 16-bit index.
  - Compared against `res_*` when the valid bit emerges.
  - A vector is in error if any of the three buses mismatches. It counts once, not once per bus.
- `first_err_idx` is written only while it still reads FFFF.
- `err_count` increments by 1 per erroring vector and saturates.
- DONE holds `done`, `pass`, `err_count` and `first_err_idx` stable until the next `start`.
- DONE→RUN on `start`, with the same clearing as IDLE→RUN.
- `start` is ignored in RUN and DRAIN.

## Timing
- Reset values:
  - State is IDLE.
  - All `drv_*`, `busy`, `done`, `pass` and `err_count` are 0.
  - `first_err_idx` is FFFF.
  - The pipeline valid bits are 0.
- Reset mid-run aborts immediately to the reset values; no partial result is kept.
- All outputs are registered.
- If `start` is sampled at edge 0, vector i is driven during cycles 1+i. `busy` is high for NUM_VECTORS+LATENCY cycles, and `done` rises at edge NUM_VECTORS+LATENCY+1.
- With LATENCY=0 the check compares `res_*` in the same cycle the vector is driven. The DUT path is combinational, and the result is registered at the cycle's end.
- The last vector's error contribution is visible in `err_count` no later than the cycle `done` rises.

## Structure
- Package `stim_check_pkg` holds:
  - width constants SMALL_W=2, QUAD_W=40, WIDE_W=70;
  - LFSR_SEED and tap positions;
  - state enum `stim_state_e`;
  - NO_ERR_IDX=16'hFFFF.
- Sub-module `lfsr40` has ports clk, reset_l, load, advance and q[39:0]. The top-level block contains the FSM, the expected-value pipeline and the scoreboard.

## Test plan
- Correct incrementer, NUM_VECTORS=4, LATENCY=0, `start` at edge 0 → vectors FF../0/seed-based driven in cycles 1–4. `done` rises at edge 5 with `pass`=1, `err_count`=0 and `first_err_idx`=FFFF.
- Incrementer with result delayed 2 cycles, LATENCY=2 → `pass`=1 and `busy` high for NUM_VECTORS+2 cycles. The same DUT with LATENCY=0 → `err_count`≥NUM_VECTORS-2.
- Wide path forced to drop the carry above bit 63 → index 0 fails (all-ones+1 ≠ 0), so `first_err_idx`=0 and `pass`=0.
- `res_small` stuck at 2'b01 for NUM_VECTORS=8 → vectors 1 and every i with i[1:0]=0 (i=4) pass on the small path. `err_count`=6 and `first_err_idx`=0.
- `reset_l` dropped at vector 100 of 256 → all outputs return to reset values within the same cycle (asynchronous). A fresh `start` completes a full 256-vector run with `pass`=1.
- `start` pulsed mid-RUN and again in DONE → the first pulse is ignored and the run length is unchanged. The second restarts the run, clearing `err_count` and `first_err_idx`.

Source files
------------

// File: rtl/stim_check_pkg.sv
// Shared constants and types for the stim_check stimulus/scoreboard engine.
package stim_check_pkg;

  localparam int SMALL_W = 2;
  localparam int QUAD_W  = 40;
  localparam int WIDE_W  = 70;

  localparam logic [39:0] LFSR_SEED  = 40'h1;
  localparam int          LFSR_TAP_A = 39;
  localparam int          LFSR_TAP_B = 37;
  localparam int          LFSR_TAP_C = 20;
  localparam int          LFSR_TAP_D = 18;

  localparam logic [15:0] NO_ERR_IDX = 16'hFFFF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } stim_state_e;

  typedef struct packed {
    logic               valid;
    logic [15:0]        idx;
    logic [SMALL_W-1:0] exp_small;
    logic [QUAD_W-1:0]  exp_quad;
    logic [WIDE_W-1:0]  exp_wide;
  } exp_entry_t;

endpackage

// File: rtl/stim_check_if.sv
// Bundle of run control, stimulus, returned results and run status for stim_check.
interface stim_check_if;
  import stim_check_pkg::*;

  logic               start;
  logic [SMALL_W-1:0] drv_small;
  logic [QUAD_W-1:0]  drv_quad;
  logic [WIDE_W-1:0]  drv_wide;
  logic [SMALL_W-1:0] res_small;
  logic [QUAD_W-1:0]  res_quad;
  logic [WIDE_W-1:0]  res_wide;
  logic               busy;
  logic               done;
  logic               pass;
  logic [15:0]        err_count;
  logic [15:0]        first_err_idx;

  modport master (
    input  start, res_small, res_quad, res_wide,
    output drv_small, drv_quad, drv_wide,
    output busy, done, pass, err_count, first_err_idx
  );

  modport slave (
    output start, res_small, res_quad, res_wide,
    input  drv_small, drv_quad, drv_wide,
    input  busy, done, pass, err_count, first_err_idx
  );

endinterface

// File: rtl/stim_check_lfsr40.sv
// 40-bit Fibonacci LFSR feeding the pseudo-random part of the vector sequence.
module lfsr40
  import stim_check_pkg::*;
(
  input  logic        clk,
  input  logic        reset_l,
  input  logic        load,
  input  logic        advance,
  output logic [39:0] q
);

  logic feedback;

  assign feedback = q[LFSR_TAP_A] ^ q[LFSR_TAP_B] ^ q[LFSR_TAP_C] ^ q[LFSR_TAP_D];

  // Seed on load, otherwise shift left with the tap feedback when advanced.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      q <= LFSR_SEED;
    end else if (load) begin
      q <= LFSR_SEED;
    end else if (advance) begin
      q <= {q[38:0], feedback};
    end
  end

endmodule

// File: rtl/stim_check.sv
// Stimulus engine: drives the increment datapath, delays expected values by
// LATENCY cycles and scores the returned results.
module stim_check
  import stim_check_pkg::*;
#(
  parameter int NUM_VECTORS = 256,
  parameter int LATENCY     = 0
) (
  input logic          clk,
  input logic          reset_l,
  stim_check_if.master bus
);

  localparam logic [15:0] LAST_IDX   = 16'(NUM_VECTORS - 1);
  localparam logic [2:0]  DRAIN_LAST = 3'((LATENCY > 0) ? (LATENCY - 1) : 0);

  stim_state_e        state;
  logic [15:0]        vec_idx;
  logic [2:0]         drain_cnt;
  logic [39:0]        lfsr_q;
  logic               start_ok;
  logic               lfsr_adv;
  logic [SMALL_W-1:0] nxt_small;
  logic [QUAD_W-1:0]  nxt_quad;
  logic [WIDE_W-1:0]  nxt_wide;
  exp_entry_t         nxt_entry;
  exp_entry_t         pipe [LATENCY+1];
  exp_entry_t         chk;
  logic               mismatch;
  logic [15:0]        err_next;

  assign start_ok = bus.start && ((state == ST_IDLE) || (state == ST_DONE));
  assign lfsr_adv = (state == ST_RUN) && (vec_idx >= 16'd2);

  lfsr40 u_lfsr (
    .clk     (clk),
    .reset_l (reset_l),
    .load    (start_ok),
    .advance (lfsr_adv),
    .q       (lfsr_q)
  );

  // Pick the vector for the current index and its expected increment.
  always_comb begin
    nxt_small = '0;
    nxt_quad  = '0;
    nxt_wide  = '0;
    nxt_entry = '0;
    if (state == ST_RUN) begin
      if (vec_idx == 16'd0) begin
        nxt_small = '1;
        nxt_quad  = '1;
        nxt_wide  = '1;
      end else if (vec_idx != 16'd1) begin
        nxt_small = vec_idx[1:0];
        nxt_quad  = lfsr_q;
        nxt_wide  = {lfsr_q[29:0], lfsr_q};
      end
      nxt_entry.valid     = 1'b1;
      nxt_entry.idx       = vec_idx;
      nxt_entry.exp_small = nxt_small + 2'd1;
      nxt_entry.exp_quad  = nxt_quad + 40'd1;
      nxt_entry.exp_wide  = nxt_wide + 70'd1;
    end
  end

  assign chk      = pipe[LATENCY];
  assign mismatch = chk.valid && ((bus.res_small != chk.exp_small) ||
                                  (bus.res_quad  != chk.exp_quad)  ||
                                  (bus.res_wide  != chk.exp_wide));
  assign err_next = (mismatch && (bus.err_count != 16'hFFFF)) ?
                    (bus.err_count + 16'd1) : bus.err_count;

  // Run sequencing plus the status flags derived from it.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state     <= ST_IDLE;
      vec_idx   <= '0;
      drain_cnt <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.pass  <= 1'b0;
    end else begin
      bus.busy <= (state == ST_RUN) || (state == ST_DRAIN);
      bus.done <= (state == ST_DONE) && !start_ok;
      bus.pass <= (state == ST_DONE) && !start_ok && (err_next == 16'd0);
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            state   <= ST_RUN;
            vec_idx <= '0;
          end
        end
        ST_RUN: begin
          if (vec_idx == LAST_IDX) begin
            state     <= (LATENCY == 0) ? ST_DONE : ST_DRAIN;
            drain_cnt <= '0;
          end else begin
            vec_idx <= vec_idx + 16'd1;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            state <= ST_DONE;
          end else begin
            drain_cnt <= drain_cnt + 3'd1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Register the drive buses and shift expected values toward the compare point.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bus.drv_small <= '0;
      bus.drv_quad  <= '0;
      bus.drv_wide  <= '0;
      for (int k = 0; k <= LATENCY; k++) pipe[k] <= '0;
    end else begin
      bus.drv_small <= nxt_small;
      bus.drv_quad  <= nxt_quad;
      bus.drv_wide  <= nxt_wide;
      pipe[0]       <= nxt_entry;
      for (int k = 1; k <= LATENCY; k++) pipe[k] <= pipe[k-1];
    end
  end

  // Score each emerging vector once, remembering the first failure.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      bus.err_count     <= '0;
      bus.first_err_idx <= NO_ERR_IDX;
    end else if (start_ok) begin
      bus.err_count     <= '0;
      bus.first_err_idx <= NO_ERR_IDX;
    end else begin
      bus.err_count <= err_next;
      if (mismatch && (bus.first_err_idx == NO_ERR_IDX)) begin
        bus.first_err_idx <= chk.idx;
      end
    end
  end

endmodule

// File: tb/tb_stim_check.sv
// Bench for stim_check: a zero-latency short-run instance driven through a table
// of faulty-incrementer scenarios, and a long two-cycle-latency instance.
module tb_stim_check;
  import stim_check_pkg::*;

  localparam int NA = 8;
  localparam int NB = 256;
  localparam int LB = 2;

  typedef struct {
    int          mode;
    logic [7:0]  mask;
    logic        expPass;
    logic [15:0] expErr;
    logic [15:0] expFirst;
  } run_vec_t;

  logic clk = 1'b0;
  logic reset_l;
  int   checks = 0;
  int   errors = 0;
  int   modeA;
  logic corrA;
  logic [1:0]   xorS;
  logic [39:0]  xorQ;
  logic [69:0]  xorW;
  logic [111:0] incA1, incA2, incB1, incB2;
  run_vec_t runTable [10];

  always #5 clk = ~clk;

  stim_check_if busA ();
  stim_check_if busB ();

  stim_check #(.NUM_VECTORS(NA), .LATENCY(0)) dutA (
    .clk (clk), .reset_l (reset_l), .bus (busA)
  );

  stim_check #(.NUM_VECTORS(NB), .LATENCY(LB)) dutB (
    .clk (clk), .reset_l (reset_l), .bus (busB)
  );

  // Delay lines for the "incrementer with two cycles of latency" datapaths.
  always @(posedge clk) begin
    incA1 <= {busA.drv_small + 2'd1, busA.drv_quad + 40'd1, busA.drv_wide + 70'd1};
    incA2 <= incA1;
    incB1 <= {busB.drv_small + 2'd1, busB.drv_quad + 40'd1, busB.drv_wide + 70'd1};
    incB2 <= incB1;
  end

  // Datapath under test for instance A, with selectable faults.
  always_comb begin
    busA.res_small = busA.drv_small + 2'd1;
    busA.res_quad  = busA.drv_quad + 40'd1;
    busA.res_wide  = busA.drv_wide + 70'd1;
    case (modeA)
      1: {busA.res_small, busA.res_quad, busA.res_wide} = incA2;
      2: busA.res_wide = {busA.drv_wide[69:64], busA.drv_wide[63:0] + 64'd1};
      3: busA.res_small = 2'b01;
      4: begin
        busA.res_small = busA.drv_small;
        busA.res_quad  = busA.drv_quad;
        busA.res_wide  = busA.drv_wide;
      end
      default: ;
    endcase
    if (corrA) begin
      busA.res_small = busA.res_small ^ xorS;
      busA.res_quad  = busA.res_quad ^ xorQ;
      busA.res_wide  = busA.res_wide ^ xorW;
    end
  end

  // Instance B sees a correct incrementer delayed by two cycles.
  always_comb begin
    busB.res_small = incB2[111:110];
    busB.res_quad  = incB2[109:70];
    busB.res_wide  = incB2[69:0];
  end

  function automatic logic [39:0] lfsrStep(input logic [39:0] v);
    return {v[38:0], v[39] ^ v[37] ^ v[20] ^ v[18]};
  endfunction

  function automatic logic [111:0] modelVec(input int i, input logic [39:0] l);
    logic [1:0] s;
    if (i == 0) return '1;
    if (i == 1) return '0;
    s = 2'(i);
    return {s, l, l[29:0], l};
  endfunction

  task automatic checkOutput(input string name, input logic [111:0] actual,
                             input logic [111:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic checkMin(input string name, input int actual, input int minimum);
    checks++;
    if (actual < minimum) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected at least %0d", name, actual, minimum);
    end
  endtask

  task automatic checkIdle(input string tag, input logic busy, input logic done,
                           input logic pass, input logic [15:0] err,
                           input logic [15:0] first, input logic [111:0] drv);
    checkOutput({tag, " busy"}, busy, 1'b0);
    checkOutput({tag, " done"}, done, 1'b0);
    checkOutput({tag, " pass"}, pass, 1'b0);
    checkOutput({tag, " err_count"}, err, 16'd0);
    checkOutput({tag, " first_err_idx"}, first, NO_ERR_IDX);
    checkOutput({tag, " drv"}, drv, 112'd0);
  endtask

  task automatic applyStimulus(input int mode, input logic [7:0] mask, input string tag);
    logic [39:0]  l;
    logic [111:0] v;
    l     = LFSR_SEED;
    modeA = mode;
    corrA = 1'b0;
    busA.start = 1'b1;
    @(posedge clk); #1;
    busA.start = 1'b0;
    for (int i = 0; i < NA; i++) begin
      @(posedge clk); #1;
      v = modelVec(i, l);
      if (i >= 2) l = lfsrStep(l);
      checkOutput({tag, " drv"}, {busA.drv_small, busA.drv_quad, busA.drv_wide}, v);
      xorS  = '0;
      xorQ  = '0;
      xorW  = '0;
      corrA = mask[3'(i)];
      if (mask[3'(i)]) begin
        case ($urandom_range(0, 2))
          0:       xorS = 2'(1 << $urandom_range(0, 1));
          1:       xorQ = 40'd1 << $urandom_range(0, 39);
          default: xorW = 70'd1 << $urandom_range(0, 69);
        endcase
      end
    end
    checkOutput({tag, " done-before-end"}, busA.done, 1'b0);
    @(posedge clk); #1;
    corrA = 1'b0;
    checkOutput({tag, " done"}, busA.done, 1'b1);
  endtask

  task automatic waitDoneA(output int edges);
    edges = 0;
    while (!busA.done && edges < 50) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic runB(output int edges, output int busyCycles);
    busB.start = 1'b1;
    @(posedge clk); #1;
    busB.start = 1'b0;
    edges      = 0;
    busyCycles = 0;
    while (!busB.done && edges < 400) begin
      @(posedge clk); #1;
      edges++;
      if (busB.busy) busyCycles++;
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int          edges;
    int          busyCycles;
    logic [7:0]  m;
    logic [15:0] first;

    runTable[0] = '{0, 8'h00, 1'b1, 16'd0, NO_ERR_IDX};
    runTable[1] = '{2, 8'h00, 1'b0, 16'd1, 16'd0};
    runTable[2] = '{3, 8'h00, 1'b0, 16'd6, 16'd0};
    runTable[3] = '{4, 8'h00, 1'b0, 16'd8, 16'd0};
    for (int r = 4; r < 10; r++) begin
      m     = 8'($urandom_range(0, 255));
      first = NO_ERR_IDX;
      for (int b = NA - 1; b >= 0; b--) if (m[3'(b)]) first = 16'(b);
      runTable[r] = '{6, m, (m == 8'h00), 16'($countones(m)), first};
    end

    modeA      = 0;
    corrA      = 1'b0;
    xorS       = '0;
    xorQ       = '0;
    xorW       = '0;
    busA.start = 1'b0;
    busB.start = 1'b0;
    reset_l    = 1'b0;
    #12;
    checkIdle("resetA", busA.busy, busA.done, busA.pass, busA.err_count,
              busA.first_err_idx, {busA.drv_small, busA.drv_quad, busA.drv_wide});
    checkIdle("resetB", busB.busy, busB.done, busB.pass, busB.err_count,
              busB.first_err_idx, {busB.drv_small, busB.drv_quad, busB.drv_wide});
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);

    for (int r = 0; r < 10; r++) begin
      applyStimulus(runTable[r].mode, runTable[r].mask, $sformatf("run%0d", r));
      checkOutput($sformatf("run%0d pass", r), busA.pass, runTable[r].expPass);
      checkOutput($sformatf("run%0d err_count", r), busA.err_count, runTable[r].expErr);
      checkOutput($sformatf("run%0d first_err_idx", r), busA.first_err_idx,
                  runTable[r].expFirst);
    end

    applyStimulus(1, 8'h00, "latmismatch");
    checkMin("latmismatch err_count", int'(busA.err_count), NA - 2);
    checkOutput("latmismatch pass", busA.pass, 1'b0);

    modeA      = 4;
    busA.start = 1'b1;
    @(posedge clk); #1;
    busA.start = 1'b0;
    edges      = 0;
    while (!busA.done && edges < 50) begin
      @(posedge clk); #1;
      edges++;
      busA.start = (edges == 3);
    end
    busA.start = 1'b0;
    checkOutput("midrun-start run length", 112'(edges), 112'(NA + 1));
    checkOutput("midrun-start err_count", busA.err_count, 16'(NA));
    checkOutput("midrun-start first_err_idx", busA.first_err_idx, 16'd0);

    modeA      = 0;
    busA.start = 1'b1;
    @(posedge clk); #1;
    busA.start = 1'b0;
    checkOutput("restart err_count", busA.err_count, 16'd0);
    checkOutput("restart first_err_idx", busA.first_err_idx, NO_ERR_IDX);
    checkOutput("restart done", busA.done, 1'b0);
    waitDoneA(edges);
    checkOutput("restart run length", 112'(edges), 112'(NA + 1));
    checkOutput("restart pass", busA.pass, 1'b1);

    runB(edges, busyCycles);
    checkOutput("latB done edge", 112'(edges), 112'(NB + LB + 1));
    checkOutput("latB busy cycles", 112'(busyCycles), 112'(NB + LB));
    checkOutput("latB pass", busB.pass, 1'b1);
    checkOutput("latB err_count", busB.err_count, 16'd0);
    checkOutput("latB first_err_idx", busB.first_err_idx, NO_ERR_IDX);

    busB.start = 1'b1;
    @(posedge clk); #1;
    busB.start = 1'b0;
    repeat (101) @(posedge clk);
    #1;
    checkOutput("abort busy before", busB.busy, 1'b1);
    checkOutput("abort vector100 small", busB.drv_small, 2'(100));
    reset_l = 1'b0;
    #1;
    checkIdle("abortB", busB.busy, busB.done, busB.pass, busB.err_count,
              busB.first_err_idx, {busB.drv_small, busB.drv_quad, busB.drv_wide});
    @(negedge clk);
    reset_l = 1'b1;
    @(negedge clk);
    runB(edges, busyCycles);
    checkOutput("after-abort done edge", 112'(edges), 112'(NB + LB + 1));
    checkOutput("after-abort pass", busB.pass, 1'b1);
    checkOutput("after-abort err_count", busB.err_count, 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
